// File: rtl/miner_pkg.sv
// Shared widths, FSM state type and small helpers for the odo_keccak job
// controller and its in-flight tracking.
package miner_pkg;

   localparam int HEADER_W = 608;
   localparam int TARGET_W = 256;
   localparam int NONCE_W  = 32;
   localparam int DP_IN_W  = NONCE_W + HEADER_W;
   localparam int CNT_W    = 10;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } sched_state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/nonce_scheduler_if.sv
// Work, datapath and found-slot signals of nonce_scheduler. The slave modport
// is the scheduler's view; master is the view of the surrounding logic.
interface nonce_scheduler_if;
   import miner_pkg::*;

   logic                work_valid;
   logic                work_ready;
   logic [HEADER_W-1:0] work_header;
   logic [TARGET_W-1:0] work_target;
   logic [NONCE_W-1:0]  work_nstart;
   logic [NONCE_W-1:0]  work_nend;

   logic                dp_read;
   logic [DP_IN_W-1:0]  dp_in;
   logic [TARGET_W-1:0] dp_target;
   logic                dp_write;
   logic                dp_hit;

   logic                found_valid;
   logic [NONCE_W-1:0]  found_nonce;
   logic                found_ack;

   modport slave (
      input  work_valid, work_header, work_target, work_nstart, work_nend,
      output work_ready,
      output dp_read, dp_in, dp_target,
      input  dp_write, dp_hit,
      output found_valid, found_nonce,
      input  found_ack
   );

   modport master (
      output work_valid, work_header, work_target, work_nstart, work_nend,
      input  work_ready,
      input  dp_read, dp_in, dp_target,
      output dp_write, dp_hit,
      input  found_valid, found_nonce,
      output found_ack
   );

endinterface

// File: rtl/nonce_scheduler_inflight_fifo.sv
// In-flight nonce FIFO: entry = {discard, nonce}. discard_all marks every stored
// entry stale; a push+pop in the same cycle is accepted even when full.
module inflight_fifo
   import miner_pkg::*;
#(
   parameter int  WIDTH = NONCE_W + 1,
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             discard_all,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign count   = count_reg;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr_reg];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // A push in the same cycle as discard_all keeps its own discard bit.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (discard_all) mem[i][WIDTH-1] <= 1'b1;
      end
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/nonce_scheduler.sv
// Job controller for the odo_keccak pipeline: issues nonces, pairs results with
// them and reports winners. Define NONCE_SCHED_STATS_EN for hit/drop counters.
module nonce_scheduler
   import miner_pkg::*;
#(
   parameter int ISSUE_INTERVAL = 1000,
   parameter int INFLIGHT_DEPTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   nonce_scheduler_if.slave   bus,
   input  logic               abort,
   output logic               busy,
   output logic               exhausted,
   output logic               proto_err
`ifdef NONCE_SCHED_STATS_EN
   ,
   output logic [31:0]        hit_cnt,
   output logic [31:0]        drop_cnt
`endif
);

   localparam int               FIFO_CW  = $clog2(INFLIGHT_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(ISSUE_INTERVAL - 1);

   sched_state_t        state_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [NONCE_W-1:0]  nonce_reg;
   logic [NONCE_W-1:0]  nend_reg;
   logic [HEADER_W-1:0] header_reg;
   logic [TARGET_W-1:0] target_reg;
   logic                exhausted_reg;
   logic                proto_err_reg;
   logic                found_valid_reg;
   logic [NONCE_W-1:0]  found_nonce_reg;

   logic                fifo_full;
   logic                fifo_empty;
   logic [NONCE_W:0]    fifo_head;
   logic [FIFO_CW-1:0]  fifo_count;

   logic                accept;
   logic                issue;
   logic                pop;
   logic                head_discard;
   logic                report;
   logic                load;
   logic                drain_done;

   assign accept       = (state_reg == IDLE) && bus.work_valid;
   assign issue        = (state_reg == RUN) && (cnt_reg == CNT_TERM) && !fifo_full;
   assign pop          = bus.dp_write && !fifo_empty;
   // A result popped in the abort cycle belongs to the old job as well.
   assign head_discard = fifo_head[NONCE_W] || abort;
   assign report       = pop && bus.dp_hit && !head_discard;
   assign load         = report && (!found_valid_reg || bus.found_ack);
   assign drain_done   = fifo_empty || ((fifo_count == FIFO_CW'(1)) && pop);

   inflight_fifo #(
      .WIDTH (NONCE_W + 1),
      .DEPTH (INFLIGHT_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (issue),
      .push_data   ({abort, nonce_reg}),
      .pop         (pop),
      .discard_all (abort && (state_reg != IDLE)),
      .head        (fifo_head),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count       (fifo_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         nonce_reg     <= '0;
         nend_reg      <= '0;
         header_reg    <= '0;
         target_reg    <= '0;
         exhausted_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.work_valid) begin
                  header_reg    <= bus.work_header;
                  target_reg    <= bus.work_target;
                  nonce_reg     <= bus.work_nstart;
                  nend_reg      <= bus.work_nend;
                  cnt_reg       <= CNT_TERM;
                  if (bus.work_nstart > bus.work_nend) begin
                     state_reg     <= DRAIN;
                     exhausted_reg <= 1'b1;
                  end else begin
                     state_reg     <= RUN;
                     exhausted_reg <= 1'b0;
                  end
               end
            end
            RUN: begin
               // Counter parks at its terminal value while the FIFO is full.
               if (issue) begin
                  nonce_reg <= nonce_reg + 32'd1;
                  cnt_reg   <= '0;
                  if (nonce_reg == nend_reg) begin
                     state_reg     <= DRAIN;
                     exhausted_reg <= 1'b1;
                  end
               end else if (cnt_reg != CNT_TERM) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
               if (abort) state_reg <= DRAIN;
            end
            DRAIN: begin
               if (drain_done) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         found_valid_reg <= 1'b0;
         found_nonce_reg <= '0;
         proto_err_reg   <= 1'b0;
      end else begin
         if (load) begin
            found_valid_reg <= 1'b1;
            found_nonce_reg <= fifo_head[NONCE_W-1:0];
         end else if (bus.found_ack) begin
            found_valid_reg <= 1'b0;
         end
         if (bus.dp_write && fifo_empty) proto_err_reg <= 1'b1;
      end
   end

`ifdef NONCE_SCHED_STATS_EN
   logic [31:0] hit_cnt_reg;
   logic [31:0] drop_cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt_reg  <= '0;
         drop_cnt_reg <= '0;
      end else if (accept) begin
         hit_cnt_reg  <= '0;
         drop_cnt_reg <= '0;
      end else begin
         if (load)            hit_cnt_reg  <= sat_inc(hit_cnt_reg);
         if (report && !load) drop_cnt_reg <= sat_inc(drop_cnt_reg);
      end
   end

   assign hit_cnt  = hit_cnt_reg;
   assign drop_cnt = drop_cnt_reg;
`endif

   assign bus.work_ready  = (state_reg == IDLE);
   assign bus.dp_read     = issue;
   assign bus.dp_in       = {nonce_reg, header_reg};
   assign bus.dp_target   = target_reg;
   assign bus.found_valid = found_valid_reg;
   assign bus.found_nonce = found_nonce_reg;
   assign busy            = (state_reg != IDLE);
   assign exhausted       = exhausted_reg;
   assign proto_err       = proto_err_reg;

endmodule
